priority_encoder_8to3: RTL

//  Registered 8-to-3 priority encoder with request capture: the inverse of the 3-to-8 decoder.

---
 rtl/priority_encoder_8to3_pkg.sv | 10 +
 rtl/priority_encoder_8to3_if.sv | 23 ++
 rtl/priority_encoder_8to3_prio.sv | 18 +
 rtl/priority_encoder_8to3.sv | 93 +++++++++
 4 files changed

// File: rtl/priority_encoder_8to3_pkg.sv
// Shared sizing and FSM encoding for the 8-to-3 request priority encoder.
package enc_pkg;
  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;
endpackage

// File: rtl/priority_encoder_8to3_if.sv
// Request/code bundle; slave is the encoder side, master is the requester/consumer side.
interface priority_encoder_8to3_if;
  import enc_pkg::*;

  logic [N_REQ-1:0]  req_i;
  logic [N_REQ-1:0]  mask_i;
  logic              clr_i;
  logic              ready_i;
  logic [CODE_W-1:0] code_o;
  logic              valid_o;
  logic [N_REQ-1:0]  pending_o;
  logic              overflow_o;

  modport slave (
    input  req_i, mask_i, clr_i, ready_i,
    output code_o, valid_o, pending_o, overflow_o
  );

  modport master (
    output req_i, mask_i, clr_i, ready_i,
    input  code_o, valid_o, pending_o, overflow_o
  );
endinterface

// File: rtl/priority_encoder_8to3_prio.sv
// Combinational 8-bit priority encoder, highest set index wins; zero latency, no flow control.
module prio_enc8
  import enc_pkg::*;
(
  input  logic [N_REQ-1:0]  in_i,
  output logic [CODE_W-1:0] code_o,
  output logic              any_o
);

  always_comb begin
    code_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (in_i[i]) code_o = CODE_W'(i);
    end
    any_o = |in_i;
  end

endmodule

// File: rtl/priority_encoder_8to3.sv
// Captures request lines and presents them one code at a time, highest index first.
// Code valid one edge after capture; held frozen while ready_i is low, 1 code/cycle when high.
module priority_encoder_8to3
  import enc_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  priority_encoder_8to3_if.slave          bus
);

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic              overflow_q, overflow_d;

  logic [N_REQ-1:0]  capture;
  logic [N_REQ-1:0]  cand;
  logic [CODE_W-1:0] sel;
  logic              cand_any;
  logic              load;
  logic [N_REQ-1:0]  sel_oh;

  assign capture = pending_q | bus.req_i;
  assign cand    = capture & ~bus.mask_i;

  prio_enc8 u_prio (
    .in_i   (cand),
    .code_o (sel),
    .any_o  (cand_any)
  );

  // A new code loads when the output slot is empty or is being handed off this edge.
  assign load   = cand_any && ((state_q == ST_IDLE) || bus.ready_i);
  assign sel_oh = N_REQ'(1) << sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      code_q     <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    pending_d  = load ? (capture & ~sel_oh) : capture;
    overflow_d = overflow_q | (|(bus.req_i & pending_q));
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_HOLD;
          code_d  = sel;
        end
      end
      ST_HOLD: begin
        if (bus.ready_i) begin
          if (load) begin
            code_d = sel;
          end else begin
            state_d = ST_IDLE;
            code_d  = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        code_d  = '0;
      end
    endcase
    // Flush wins over everything, including requests and a handshake on the same edge.
    if (bus.clr_i) begin
      state_d    = ST_IDLE;
      code_d     = '0;
      pending_d  = '0;
      overflow_d = 1'b0;
    end
  end

  always_comb begin
    bus.valid_o    = (state_q == ST_HOLD);
    bus.code_o     = code_q;
    bus.pending_o  = pending_q;
    bus.overflow_o = overflow_q;
  end

endmodule
